// File: rtl/avalon_mem_master_if.sv
// CPU request/response channel plus Avalon-MM master bus for avalon_mem_master.
interface avalon_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  readdata, waitrequest,
        output req_ready, resp_valid, resp_error, resp_rdata,
        output address, read, write, byteenable, writedata
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output readdata, waitrequest,
        input  req_ready, resp_valid, resp_error, resp_rdata,
        input  address, read, write, byteenable, writedata
    );
endinterface

// File: rtl/avalon_mem_master.sv
// Single-transfer Avalon-MM master: turns byte/half/word CPU loads and stores into
// lane-aligned Avalon accesses, with optional waitrequest timeout.
module avalon_mem_master #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset,
    avalon_mem_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam int CNT_W  = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam int LIM_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

    state_t           state;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             sgn_q;

    logic             bad_req;
    logic [3:0]       be_c;
    logic [31:0]      wd_c;

    // Selected byte/half moved to bit 0, then zero- or sign-extended.
    function automatic logic [31:0] extract_load(input logic [31:0] rd, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        bad_req = 1'b0;
        be_c    = 4'b0000;
        wd_c    = 32'h0;
        case (bus.req_size)
            2'b00: begin
                be_c = 4'b0001 << bus.req_addr[1:0];
                wd_c = {24'h0, bus.req_wdata[7:0]} << {bus.req_addr[1:0], 3'b000};
            end
            2'b01: begin
                bad_req = bus.req_addr[0];
                be_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wd_c    = bus.req_addr[1] ? {bus.req_wdata[15:0], 16'h0}
                                          : {16'h0, bus.req_wdata[15:0]};
            end
            2'b10: begin
                bad_req = |bus.req_addr[1:0];
                be_c    = 4'b1111;
                wd_c    = bus.req_wdata;
            end
            default: bad_req = 1'b1;
        endcase
    end

    assign bus.req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            stall_cnt       <= '0;
            size_q          <= 2'b00;
            off_q           <= 2'b00;
            sgn_q           <= 1'b0;
            bus.read        <= 1'b0;
            bus.write       <= 1'b0;
            bus.address     <= 32'h0;
            bus.byteenable  <= 4'b0000;
            bus.writedata   <= 32'h0;
            bus.resp_valid  <= 1'b0;
            bus.resp_error  <= 1'b0;
            bus.resp_rdata  <= 32'h0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q         <= bus.req_size;
                        off_q          <= bus.req_addr[1:0];
                        sgn_q          <= bus.req_signed;
                        bus.resp_rdata <= 32'h0;
                        bus.resp_error <= 1'b0;
                        if (bad_req) begin
                            // Rejected requests never touch the bus.
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                        end else begin
                            state          <= bus.req_write ? WRITE : READ;
                            bus.read       <= ~bus.req_write;
                            bus.write      <= bus.req_write;
                            bus.address    <= {bus.req_addr[31:2], 2'b00};
                            bus.byteenable <= be_c;
                            bus.writedata  <= bus.req_write ? wd_c : 32'h0;
                            stall_cnt      <= '0;
                        end
                    end
                end
                READ, WRITE: begin
                    if (!bus.waitrequest) begin
                        state          <= DONE;
                        bus.read       <= 1'b0;
                        bus.write      <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= (state == READ)
                                        ? extract_load(bus.readdata, size_q, off_q, sgn_q) : 32'h0;
                    end else if (WAIT_LIMIT > 0 && stall_cnt == CNT_W'(LIM_M1)) begin
                        // This stall cycle is the WAIT_LIMIT-th: abandon the transfer.
                        state          <= DONE;
                        bus.read       <= 1'b0;
                        bus.write      <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b1;
                        bus.resp_rdata <= 32'h0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_mem_master.sv
// Randomized scoreboard bench for avalon_mem_master acting as CPU and Avalon slave.
module tb_avalon_mem_master;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_mem_master_if bus();

    avalon_mem_master #(.WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.read || bus.write)
                check("single_strobe", {31'h0, bus.read & bus.write}, 32'h0);
            if (bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("resp_error", {31'h0, bus.resp_error}, {31'h0, e.err});
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic wait_ready();
        int wt = 0;
        while (!bus.req_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        check("req_ready", {31'h0, bus.req_ready}, 32'h1);
    endtask

    task automatic scramble_req();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    // One transfer: issues the request, plays the slave for `stalls` wait cycles.
    task automatic xfer(input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int stalls);
        int          nb, off, n;
        logic        err;
        logic [31:0] mask, ebe, ewd, v;
        exp_t        e;
        off  = int'(addr[1:0]);
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err  = (size == 2'd3) || (off % nb != 0);
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        ebe  = ((32'h1 << nb) - 32'h1) << off;
        ewd  = w ? (wdata & mask) << (8 * off) : 32'h0;
        v    = (rd >> (8 * off)) & mask;
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;

        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.acc = cyc;
        if (err) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = 1;
        end else if (stalls >= WL) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = WL + 1;
        end else begin
            e.err = 1'b0; e.rdata = w ? 32'h0 : v; e.lat = stalls + 2;
        end
        sbq.push_back(e);
        @(negedge clk);
        scramble_req();

        if (err) begin
            check("no_strobe_on_error", {30'h0, bus.read, bus.write}, 32'h0);
        end else begin
            n = (stalls >= WL) ? WL : stalls + 1;
            for (int k = 0; k < n; k++) begin
                bus.waitrequest = (k < stalls);
                bus.readdata    = (k < stalls) ? $urandom : rd;
                check("strobe", {30'h0, bus.read, bus.write}, w ? 32'h1 : 32'h2);
                check("address", bus.address, {addr[31:2], 2'b00});
                check("byteenable", {28'h0, bus.byteenable}, ebe);
                check("writedata", bus.writedata, ewd);
                @(negedge clk);
            end
            bus.waitrequest = 1'b0;
            check("strobe_drop", {30'h0, bus.read, bus.write}, 32'h0);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.readdata    = 32'h0;
        bus.waitrequest = 1'b0;
        scramble_req();
        repeat (2) @(negedge clk);
        check("rst_strobes", {30'h0, bus.read, bus.write}, 32'h0);
        check("rst_resp", {30'h0, bus.resp_valid, bus.resp_error}, 32'h0);
        check("rst_address", bus.address, 32'h0);
        check("rst_be", {28'h0, bus.byteenable}, 32'h0);
        check("rst_wdata", bus.writedata, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'h0, bus.req_ready}, 32'h1);

        xfer(1'b1, 2'd2, 1'b0, 32'hBFC0_0008, 32'hDEAD_BEEF, 32'h0, 0);
        xfer(1'b0, 2'd0, 1'b1, 32'hBFC0_0003, 32'h0, 32'h8012_3456, 0);
        xfer(1'b0, 2'd0, 1'b0, 32'hBFC0_0003, 32'h0, 32'h8012_3456, 0);
        xfer(1'b1, 2'd1, 1'b0, 32'hBFC0_0002, 32'h0000_ABCD, 32'h0, 3);
        xfer(1'b0, 2'd2, 1'b0, 32'hBFC0_0001, 32'h0, 32'h1234_5678, 0);
        xfer(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 1);
        xfer(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0);
        xfer(1'b0, 2'd2, 1'b0, 32'hBFC0_0004, 32'h0, 32'h5555_AAAA, 10);
        xfer(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'hFFFF_FF5A, 32'h0, WL - 1);

        for (int i = 0; i < 200; i++)
            xfer(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 6)));

        // Reset during a stalled read: the transfer vanishes without a response.
        wait_ready();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h100;
        @(negedge clk);
        scramble_req();
        bus.waitrequest = 1'b1;
        check("pre_reset_read", {31'h0, bus.read}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_abort_read", {31'h0, bus.read}, 32'h0);
        check("reset_abort_resp", {31'h0, bus.resp_valid}, 32'h0);
        check("reset_abort_ready", {31'h0, bus.req_ready}, 32'h1);
        reset = 1'b0;
        bus.waitrequest = 1'b0;
        repeat (4) @(negedge clk);

        xfer(1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0, 32'hFEDC_BA98, 2);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("queue_drained", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
